// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder reused over WIDTH cycles, LSB first, with a registered carry.
// Define SERIAL_ADD_SUB_EN to add a Sub input that turns the operation into A-B.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             CarryIn,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sub_sel;
  logic               sum_bit;
  logic               carry_bit;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = Sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_bit = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // Subtraction is A + ~B + 1, so the carry is forced and CarryIn ignored.
        if (Start) begin
          state_d = RUN;
          a_d     = OperandA;
          b_d     = sub_sel ? ~OperandB : OperandB;
          carry_d = sub_sel ? 1'b1 : CarryIn;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = carry_bit;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign Result   = res_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table plus hand sequences, results
// checked through a scoreboard queue popped on every Done pulse.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             CarryIn;
`ifdef SERIAL_ADD_SUB_EN
  logic             Sub;
`endif
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             CarryOut;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_res;
    logic             exp_c;
  } vec_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .CarryIn  (CarryIn),
`ifdef SERIAL_ADD_SUB_EN
    .Sub      (Sub),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .CarryOut (CarryOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  // Each Done pulse must match the oldest expected result still outstanding.
  always @(posedge Clk) begin
    exp_t e;
    #3;
    if (Done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("result", 32'(Result), 32'(e.res));
        check_output("carry_out", 32'(CarryOut), 32'(e.c));
      end
    end
  end

  task automatic apply_stimulus(input vec_t v, input bit expect_done);
    exp_t e;
    Start    = 1'b1;
    OperandA = v.a;
    OperandB = v.b;
    CarryIn  = v.cin;
`ifdef SERIAL_ADD_SUB_EN
    Sub      = v.sub;
`endif
    if (expect_done) begin
      e.res = v.exp_res;
      e.c   = v.exp_c;
      exp_q.push_back(e);
    end
  endtask

  // Full operation: busy cycles, Done latency, single pulse and held outputs.
  task automatic run_op(input vec_t v);
    int busy_cnt;
    int done_idx;
    busy_cnt = 0;
    done_idx = -1;
    @(negedge Clk);
    apply_stimulus(v, 1'b1);
    for (int i = 0; i < WIDTH + 5; i++) begin
      @(negedge Clk);
      if (i == 0) Start = 1'b0;
      if (Busy) busy_cnt++;
      if (Done) begin
        done_idx = i;
        break;
      end
    end
    check_output("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
    check_output("done_latency", 32'(done_idx), 32'(WIDTH));
    @(negedge Clk);
    check_output("done_one_cycle", 32'(Done), 32'd0);
    check_output("result_held", 32'(Result), 32'(v.exp_res));
    check_output("carry_held", 32'(CarryOut), 32'(v.exp_c));
  endtask

  initial begin
    vec_t v;
    int   done_idx;
    int   done_before;

    vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
`endif

    Reset    = 1'b1;
    Start    = 1'b0;
    OperandA = '0;
    OperandB = '0;
    CarryIn  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    Sub      = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check_output("reset_busy", 32'(Busy), 32'd0);
    check_output("reset_done", 32'(Done), 32'd0);
    check_output("reset_result", 32'(Result), 32'd0);
    check_output("reset_carry", 32'(CarryOut), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    foreach (vecs[i]) run_op(vecs[i]);
`ifdef SERIAL_ADD_SUB_EN
    Sub = 1'b0;
`endif

    // Start with new operands in the third RUN cycle must be ignored.
    done_before = done_count;
    done_idx = -1;
    @(negedge Clk);
    apply_stimulus('{8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0}, 1'b1);
    for (int i = 0; i < WIDTH + 5; i++) begin
      @(negedge Clk);
      if (i == 0) Start = 1'b0;
      if (i == 2) begin
        Start    = 1'b1;
        OperandA = 8'hEE;
        OperandB = 8'hEE;
        CarryIn  = 1'b1;
      end
      if (i == 3) Start = 1'b0;
      if (Done) begin
        done_idx = i;
        break;
      end
    end
    check_output("ignored_start_latency", 32'(done_idx), 32'(WIDTH));
    repeat (4) @(negedge Clk);
    check_output("ignored_start_done_count", 32'(done_count - done_before), 32'd1);
    check_output("ignored_start_result", 32'(Result), 32'h33);

    // Start held through DONE chains a second operation with no IDLE cycle.
    done_idx = -1;
    @(negedge Clk);
    apply_stimulus('{8'h10, 8'h05, 1'b0, 1'b0, 8'h15, 1'b0}, 1'b1);
    for (int i = 0; i < WIDTH + 5; i++) begin
      @(negedge Clk);
      if (i == 0) apply_stimulus('{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0}, 1'b1);
      if (Done) begin
        done_idx = i;
        break;
      end
    end
    check_output("b2b_first_latency", 32'(done_idx), 32'(WIDTH));
    @(negedge Clk);
    Start = 1'b0;
    check_output("b2b_no_idle_busy", 32'(Busy), 32'd1);
    check_output("b2b_no_idle_done", 32'(Done), 32'd0);
    done_idx = -1;
    for (int i = 0; i < WIDTH + 5; i++) begin
      @(negedge Clk);
      if (Done) begin
        done_idx = i;
        break;
      end
    end
    check_output("b2b_second_latency", 32'(done_idx), 32'(WIDTH - 1));
    @(negedge Clk);
    check_output("b2b_result", 32'(Result), 32'h03);

    // Reset in the fourth RUN cycle aborts without a Done pulse.
    done_before = done_count;
    @(negedge Clk);
    apply_stimulus('{8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (i == 0) Start = 1'b0;
    end
    check_output("pre_reset_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check_output("abort_busy", 32'(Busy), 32'd0);
    check_output("abort_done", 32'(Done), 32'd0);
    check_output("abort_result", 32'(Result), 32'd0);
    check_output("abort_carry", 32'(CarryOut), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (WIDTH + 3) @(negedge Clk);
    check_output("abort_no_done", 32'(done_count - done_before), 32'd0);
    v = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0};
    run_op(v);

    repeat (2) @(negedge Clk);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
